// File: rtl/holoblade_cmd_pkg.sv
// Shared constants, codes and FSM state type for the UART-to-SPI
// command bridge (holoblade command protocol).
package holoblade_cmd_pkg;

   localparam int CLK_HZ = 50_000_000;

   // 100 ms at the system clock rate
   localparam int DEF_TIMEOUT_CYCLES = CLK_HZ / 10;
   localparam int DEF_RESET_CYCLES   = CLK_HZ / 10;

   localparam logic [7:0] CMD_OP_WRITE = 8'h57;
   localparam logic [7:0] CMD_OP_READ  = 8'h52;
   localparam logic [7:0] CMD_OP_RESET = 8'h72;

   localparam logic [7:0] CMD_ACK = 8'h06;
   localparam logic [7:0] CMD_NAK = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_CHK,
      ST_SPI_GO,
      ST_SPI_WAIT,
      ST_RESP,
      ST_RST
   } state_e;

endpackage

// File: rtl/uart_spi_cmd_bridge_shifter.sv
// cmd_byte_shifter: N-byte MSB-first field capture with byte counter.
// done_o flags the shift that completes the field.
module cmd_byte_shifter #(
   parameter int N = 1
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           clr_i,
   input  logic           shift_i,
   input  logic [7:0]     byte_i,
   output logic [8*N-1:0] word_o,
   output logic           done_o
);

   localparam int W = 8 * N;

   logic [W-1:0] word_q, word_d;
   logic [2:0]   cnt_q, cnt_d;

   assign done_o = shift_i && (cnt_q == 3'(N - 1));
   assign word_o = word_q;

   // next field value and byte count
   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (shift_i) begin
         word_d = W'({word_q, byte_i});
         cnt_d  = done_o ? 3'd0 : cnt_q + 3'd1;
      end
   end

   // field register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_spi_cmd_bridge.sv
// Framed UART command decoder driving one SPI transaction per frame.
// Optional trailing XOR checksum byte: HOLOBLADE_CMD_CHECKSUM_EN.
module uart_spi_cmd_bridge
   import holoblade_cmd_pkg::*;
#(
   parameter int         ADDR_BYTES     = 1,
   parameter int         DATA_BYTES     = 1,
   parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int         RESET_CYCLES   = DEF_RESET_CYCLES,
   parameter logic [7:0] OP_WRITE       = CMD_OP_WRITE,
   parameter logic [7:0] OP_READ        = CMD_OP_READ,
   parameter logic [7:0] OP_RESET       = CMD_OP_RESET
) (
   input  logic                                i_clock,
   input  logic                                i_reset,
   input  logic                                i_rx_dv,
   input  logic [7:0]                          i_rx_byte,
   output logic                                o_tx_dv,
   output logic [7:0]                          o_tx_byte,
   input  logic                                i_tx_active,
   input  logic                                i_tx_done,
   output logic                                o_spi_start,
   output logic [8*(ADDR_BYTES+DATA_BYTES)-1:0] o_spi_tx_word,
   input  logic                                i_spi_busy,
   input  logic                                i_spi_done,
   input  logic [8*DATA_BYTES-1:0]             i_spi_rx_word,
   output logic                                o_reset_req,
   output logic                                o_err_timeout,
   output logic                                o_err_overrun
);

   localparam int AW = 8 * ADDR_BYTES;
   localparam int DW = 8 * DATA_BYTES;

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] RC_LAST = 32'(RESET_CYCLES - 1);

   localparam logic [DW-1:0] ACK_W = DW'(CMD_ACK) << (DW - 8);
   localparam logic [DW-1:0] NAK_W = DW'(CMD_NAK) << (DW - 8);

`ifdef HOLOBLADE_CMD_CHECKSUM_EN
   localparam state_e ST_FRAME_END = ST_CHK;
`else
   localparam state_e ST_FRAME_END = ST_SPI_GO;
`endif

   state_e        state_q, state_d;
   logic [31:0]   tmr_q, tmr_d;
   logic          rd_q, rd_d;
   logic          reset_q, reset_d;
   logic [DW-1:0] resp_q, resp_d;
   logic [3:0]    left_q, left_d;
   logic          sent_q, sent_d;
`ifdef HOLOBLADE_CMD_CHECKSUM_EN
   logic [7:0]    xor_q, xor_d;
   logic          rop_q, rop_d;
`endif

   logic          fld_clr;
   logic          addr_en, data_en;
   logic          addr_last, data_last;
   logic [AW-1:0] addr_w;
   logic [DW-1:0] data_w;

   cmd_byte_shifter #(.N(ADDR_BYTES)) u_addr (
      .clk_i   (i_clock),
      .rst_i   (i_reset),
      .clr_i   (fld_clr),
      .shift_i (addr_en),
      .byte_i  (i_rx_byte),
      .word_o  (addr_w),
      .done_o  (addr_last)
   );

   cmd_byte_shifter #(.N(DATA_BYTES)) u_data (
      .clk_i   (i_clock),
      .rst_i   (i_reset),
      .clr_i   (fld_clr),
      .shift_i (data_en),
      .byte_i  (i_rx_byte),
      .word_o  (data_w),
      .done_o  (data_last)
   );

   assign o_spi_tx_word = {addr_w, data_w};
   assign o_tx_byte     = resp_q[DW-1 -: 8];
   assign o_reset_req   = reset_q;

   // frame decode, SPI sequencing and response FSM
   always_comb begin
      state_d       = state_q;
      tmr_d         = tmr_q;
      rd_d          = rd_q;
      reset_d       = reset_q;
      resp_d        = resp_q;
      left_d        = left_q;
      sent_d        = sent_q;
`ifdef HOLOBLADE_CMD_CHECKSUM_EN
      xor_d         = xor_q;
      rop_d         = rop_q;
`endif
      fld_clr       = 1'b0;
      addr_en       = 1'b0;
      data_en       = 1'b0;
      o_spi_start   = 1'b0;
      o_tx_dv       = 1'b0;
      o_err_timeout = 1'b0;
      o_err_overrun = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_rx_dv) begin
               tmr_d = '0;
               if (i_rx_byte == OP_WRITE || i_rx_byte == OP_READ) begin
                  fld_clr = 1'b1;
                  rd_d    = (i_rx_byte == OP_READ);
                  state_d = ST_ADDR;
`ifdef HOLOBLADE_CMD_CHECKSUM_EN
                  xor_d   = i_rx_byte;
                  rop_d   = 1'b0;
`endif
               end else if (i_rx_byte == OP_RESET) begin
`ifdef HOLOBLADE_CMD_CHECKSUM_EN
                  xor_d   = i_rx_byte;
                  rop_d   = 1'b1;
                  state_d = ST_CHK;
`else
                  reset_d = 1'b1;
                  state_d = ST_RST;
`endif
               end else begin
                  resp_d  = NAK_W;
                  left_d  = 4'd1;
                  sent_d  = 1'b0;
                  state_d = ST_RESP;
               end
            end
         end

         ST_ADDR: begin
            if (i_rx_dv) begin
               addr_en = 1'b1;
               tmr_d   = '0;
`ifdef HOLOBLADE_CMD_CHECKSUM_EN
               xor_d   = xor_q ^ i_rx_byte;
`endif
               if (addr_last)
                  state_d = rd_q ? ST_FRAME_END : ST_DATA;
            end else if (tmr_q == TO_LAST) begin
               o_err_timeout = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               tmr_d = tmr_q + 32'd1;
            end
         end

         ST_DATA: begin
            if (i_rx_dv) begin
               data_en = 1'b1;
               tmr_d   = '0;
`ifdef HOLOBLADE_CMD_CHECKSUM_EN
               xor_d   = xor_q ^ i_rx_byte;
`endif
               if (data_last)
                  state_d = ST_FRAME_END;
            end else if (tmr_q == TO_LAST) begin
               o_err_timeout = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               tmr_d = tmr_q + 32'd1;
            end
         end

`ifdef HOLOBLADE_CMD_CHECKSUM_EN
         ST_CHK: begin
            if (i_rx_dv) begin
               tmr_d = '0;
               if (i_rx_byte != xor_q) begin
                  resp_d  = NAK_W;
                  left_d  = 4'd1;
                  sent_d  = 1'b0;
                  state_d = ST_RESP;
               end else if (rop_q) begin
                  reset_d = 1'b1;
                  state_d = ST_RST;
               end else begin
                  state_d = ST_SPI_GO;
               end
            end else if (tmr_q == TO_LAST) begin
               o_err_timeout = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               tmr_d = tmr_q + 32'd1;
            end
         end
`endif

         ST_SPI_GO: begin
            o_err_overrun = i_rx_dv;
            if (!i_spi_busy) begin
               o_spi_start = 1'b1;
               tmr_d       = '0;
               state_d     = ST_SPI_WAIT;
            end
         end

         ST_SPI_WAIT: begin
            o_err_overrun = i_rx_dv;
            if (i_spi_done) begin
               resp_d  = rd_q ? i_spi_rx_word : ACK_W;
               left_d  = rd_q ? 4'(DATA_BYTES) : 4'd1;
               sent_d  = 1'b0;
               state_d = ST_RESP;
            end else if (tmr_q == TO_LAST) begin
               resp_d  = NAK_W;
               left_d  = 4'd1;
               sent_d  = 1'b0;
               state_d = ST_RESP;
            end else begin
               tmr_d = tmr_q + 32'd1;
            end
         end

         ST_RESP: begin
            o_err_overrun = i_rx_dv;
            if (!sent_q) begin
               if (!i_tx_active) begin
                  o_tx_dv = 1'b1;
                  sent_d  = 1'b1;
               end
            end else if (i_tx_done) begin
               sent_d = 1'b0;
               if (left_q == 4'd1) begin
                  state_d = ST_IDLE;
               end else begin
                  resp_d = resp_q << 8;
                  left_d = left_q - 4'd1;
               end
            end
         end

         ST_RST: begin
            o_err_overrun = i_rx_dv;
            if (reset_q) begin
               tmr_d = tmr_q + 32'd1;
               if (tmr_q == RC_LAST)
                  reset_d = 1'b0;
            end else begin
               resp_d  = ACK_W;
               left_d  = 4'd1;
               sent_d  = 1'b0;
               state_d = ST_RESP;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         rd_q    <= 1'b0;
         reset_q <= 1'b0;
         resp_q  <= '0;
         left_q  <= '0;
         sent_q  <= 1'b0;
`ifdef HOLOBLADE_CMD_CHECKSUM_EN
         xor_q   <= '0;
         rop_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         rd_q    <= rd_d;
         reset_q <= reset_d;
         resp_q  <= resp_d;
         left_q  <= left_d;
         sent_q  <= sent_d;
`ifdef HOLOBLADE_CMD_CHECKSUM_EN
         xor_q   <= xor_d;
         rop_q   <= rop_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_spi_cmd_bridge.sv
// Directed bench for uart_spi_cmd_bridge (1/1 and 1/2 byte builds).
// Adds checksum bytes when HOLOBLADE_CMD_CHECKSUM_EN is defined.
module tb_uart_spi_cmd_bridge;

   localparam int TO = 50;
   localparam int RC = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        rx_dv = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        tx_dv;
   logic [7:0]  tx_byte;
   logic        tx_active = 1'b0;
   logic        tx_done = 1'b0;
   logic        spi_start;
   logic [15:0] spi_tx_word;
   logic        spi_busy = 1'b0;
   logic        spi_done = 1'b0;
   logic [7:0]  spi_rx_word = 8'h00;
   logic        reset_req;
   logic        err_to;
   logic        err_ov;

   logic        rx_dv2 = 1'b0;
   logic [7:0]  rx_byte2 = 8'h00;
   logic        tx_dv2;
   logic [7:0]  tx_byte2;
   logic        tx_done2 = 1'b0;
   logic        spi_start2;
   logic [23:0] spi_tx_word2;
   logic        spi_done2 = 1'b0;
   logic [15:0] spi_rx_word2 = 16'h0000;
   logic        reset_req2;
   logic        err_to2;
   logic        err_ov2;
   logic        idle_in2 = 1'b0;

   uart_spi_cmd_bridge #(
      .ADDR_BYTES(1), .DATA_BYTES(1),
      .TIMEOUT_CYCLES(TO), .RESET_CYCLES(RC)
   ) u_dut (
      .i_clock(clk), .i_reset(rst),
      .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
      .o_tx_dv(tx_dv), .o_tx_byte(tx_byte),
      .i_tx_active(tx_active), .i_tx_done(tx_done),
      .o_spi_start(spi_start), .o_spi_tx_word(spi_tx_word),
      .i_spi_busy(spi_busy), .i_spi_done(spi_done),
      .i_spi_rx_word(spi_rx_word),
      .o_reset_req(reset_req),
      .o_err_timeout(err_to), .o_err_overrun(err_ov)
   );

   uart_spi_cmd_bridge #(
      .ADDR_BYTES(1), .DATA_BYTES(2),
      .TIMEOUT_CYCLES(TO), .RESET_CYCLES(RC)
   ) u_dut2 (
      .i_clock(clk), .i_reset(rst),
      .i_rx_dv(rx_dv2), .i_rx_byte(rx_byte2),
      .o_tx_dv(tx_dv2), .o_tx_byte(tx_byte2),
      .i_tx_active(idle_in2), .i_tx_done(tx_done2),
      .o_spi_start(spi_start2), .o_spi_tx_word(spi_tx_word2),
      .i_spi_busy(idle_in2), .i_spi_done(spi_done2),
      .i_spi_rx_word(spi_rx_word2),
      .o_reset_req(reset_req2),
      .o_err_timeout(err_to2), .o_err_overrun(err_ov2)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // observers on the falling edge
   int          n_start = 0;
   int          n_to = 0;
   int          n_ov = 0;
   int          n_rr = 0;
   logic [15:0] last_word = 16'h0;
   logic [7:0]  txq[$];

   always @(negedge clk) begin
      if (spi_start) begin
         n_start++;
         last_word = spi_tx_word;
      end
      if (tx_dv) txq.push_back(tx_byte);
      if (err_to) n_to++;
      if (err_ov) n_ov++;
      if (reset_req) n_rr++;
   end

   // SPI master responder
   logic spi_hold = 1'b0;
   always begin
      @(negedge clk);
      if (spi_start && !spi_hold) begin
         @(posedge clk); #1 spi_busy = 1'b1;
         repeat (3) @(posedge clk);
         #1 spi_busy = 1'b0; spi_done = 1'b1;
         @(posedge clk); #1 spi_done = 1'b0;
      end
   end

   // UART transmitter responder
   always begin
      @(negedge clk);
      if (tx_dv) begin
         @(posedge clk); #1 tx_active = 1'b1;
         repeat (3) @(posedge clk);
         #1 tx_active = 1'b0; tx_done = 1'b1;
         @(posedge clk); #1 tx_done = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_byte = b;
      rx_dv = 1'b1;
      @(posedge clk); #1;
      rx_dv = 1'b0;
   endtask

   task automatic send2(input logic [7:0] b);
      rx_byte2 = b;
      rx_dv2 = 1'b1;
      @(posedge clk); #1;
      rx_dv2 = 1'b0;
   endtask

   task automatic send_frame(input logic [2:0][7:0] b, input int n);
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         x = x ^ b[i];
         send_byte(b[i]);
      end
`ifdef HOLOBLADE_CMD_CHECKSUM_EN
      if (b[0] == 8'h57 || b[0] == 8'h52 || b[0] == 8'h72)
         send_byte(x);
`endif
   endtask

   task automatic wait_resp(input int n, input string name);
      int k;
      k = 0;
      while (txq.size() < n && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      if (txq.size() < n) begin
         nvec++;
         nerr++;
         $display("FAIL %s: response got %0d bytes expected %0d",
                  name, txq.size(), n);
      end
      repeat (8) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] resp0();
      return (txq.size() > 0) ? txq[0] : 8'hxx;
   endfunction

   typedef struct packed {
      logic [2:0][7:0] b;
      int              n;
      logic [7:0]      rxw;
      int              starts;
      logic [15:0]     word;
      logic [7:0]      resp;
   } vec_t;

   function automatic vec_t mk(input logic [7:0] b0, b1, b2,
                               input int n, input logic [7:0] rxw,
                               input int st, input logic [15:0] w,
                               input logic [7:0] r);
      vec_t v;
      v.b[0] = b0;
      v.b[1] = b1;
      v.b[2] = b2;
      v.n = n;
      v.rxw = rxw;
      v.starts = st;
      v.word = w;
      v.resp = r;
      return v;
   endfunction

   vec_t vt [8];

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   s0, t0, o0, r0, k;
      logic seen;

      vt[0] = mk(8'h57, 8'h09, 8'h32, 3, 8'h00, 1, 16'h0932, 8'h06);
      vt[1] = mk(8'h52, 8'hF8, 8'h00, 2, 8'hA5, 1, 16'hF800, 8'hA5);
      vt[2] = mk(8'h41, 8'h00, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h15);
      vt[3] = mk(8'h57, 8'h12, 8'h34, 3, 8'h00, 1, 16'h1234, 8'h06);
      vt[4] = mk(8'h52, 8'h00, 8'h00, 2, 8'h3C, 1, 16'h0000, 8'h3C);
      vt[5] = mk(8'h57, 8'hFF, 8'h00, 3, 8'h00, 1, 16'hFF00, 8'h06);
      vt[6] = mk(8'h00, 8'h00, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h15);
      vt[7] = mk(8'h77, 8'h00, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h15);

      // reset state
      repeat (2) @(negedge clk);
      chk("rst tx_dv", tx_dv, 0);
      chk("rst tx_byte", tx_byte, 0);
      chk("rst spi_start", spi_start, 0);
      chk("rst spi_word", spi_tx_word, 0);
      chk("rst reset_req", reset_req, 0);
      chk("rst err_to", err_to, 0);
      chk("rst err_ov", err_ov, 0);
      chk("rst dut2 tx_dv", tx_dv2, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // table-driven frames
      for (int i = 0; i < 8; i++) begin
         v = vt[i];
         spi_rx_word = v.rxw;
         txq.delete();
         s0 = n_start;
         send_frame(v.b, v.n);
         @(negedge clk);
         chk($sformatf("v%0d latency", i), spi_start, v.starts);
         @(posedge clk); #1;
         wait_resp(1, $sformatf("v%0d", i));
         chk($sformatf("v%0d starts", i), n_start - s0, v.starts);
         if (v.starts != 0)
            chk($sformatf("v%0d word", i), last_word, v.word);
         chk($sformatf("v%0d resp", i), resp0(), v.resp);
         chk($sformatf("v%0d nresp", i), txq.size(), 1);
      end

      // reset opcode
      txq.delete();
      s0 = n_start;
      r0 = n_rr;
      send_frame({8'h00, 8'h00, 8'h72}, 1);
      @(negedge clk);
      chk("rst_op rise", reset_req, 1);
      @(posedge clk); #1;
      wait_resp(1, "rst_op");
      chk("rst_op length", n_rr - r0, RC);
      chk("rst_op resp", resp0(), 8'h06);
      chk("rst_op no spi", n_start - s0, 0);

      // inter-byte timeout
      txq.delete();
      t0 = n_to;
      send_byte(8'h57);
      send_byte(8'h09);
      k = 0;
      seen = 1'b0;
      while (!seen && k < 3 * TO) begin
         @(negedge clk);
         if (err_to) begin
            seen = 1'b1;
         end else begin
            k++;
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      chk("to seen", seen, 1);
      chk("to gap", k, TO - 1);
      repeat (10) @(posedge clk);
      #1;
      chk("to silent", txq.size(), 0);
      chk("to count", n_to - t0, 1);

      // fresh frame after timeout
      txq.delete();
      send_frame({8'h32, 8'h09, 8'h57}, 3);
      wait_resp(1, "post_to");
      chk("post_to word", last_word, 16'h0932);
      chk("post_to resp", resp0(), 8'h06);

      // byte on the terminal count wins
      txq.delete();
      t0 = n_to;
      s0 = n_start;
      send_byte(8'h57);
      send_byte(8'h09);
      repeat (TO - 1) @(posedge clk);
      #1;
      send_byte(8'h32);
`ifdef HOLOBLADE_CMD_CHECKSUM_EN
      send_byte(8'h6C);
`endif
      wait_resp(1, "edge");
      chk("edge no timeout", n_to - t0, 0);
      chk("edge starts", n_start - s0, 1);
      chk("edge word", last_word, 16'h0932);
      chk("edge resp", resp0(), 8'h06);

      // overrun in SPI_WAIT, then missing done -> NAK
      spi_hold = 1'b1;
      txq.delete();
      s0 = n_start;
      o0 = n_ov;
      send_frame({8'h34, 8'h12, 8'h57}, 3);
      repeat (3) @(posedge clk);
      #1;
      rx_byte = 8'h52;
      rx_dv = 1'b1;
      @(negedge clk);
      chk("ovr flag", err_ov, 1);
      @(posedge clk); #1;
      rx_dv = 1'b0;
      wait_resp(1, "ovr");
      chk("ovr starts", n_start - s0, 1);
      chk("ovr count", n_ov - o0, 1);
      chk("spi_to resp", resp0(), 8'h15);
      chk("spi_to nresp", txq.size(), 1);
      spi_hold = 1'b0;

      // async reset while responding
      txq.delete();
      send_frame({8'h00, 8'h00, 8'h41}, 1);
      k = 0;
      while (!tx_active && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      rst = 1'b1;
      #1;
      chk("mid_rst tx_dv", tx_dv, 0);
      chk("mid_rst tx_byte", tx_byte, 0);
      chk("mid_rst spi_word", spi_tx_word, 0);
      chk("mid_rst spi_start", spi_start, 0);
      chk("mid_rst reset_req", reset_req, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      txq.delete();
      send_frame({8'h32, 8'h09, 8'h57}, 3);
      wait_resp(1, "after_rst");
      chk("after_rst word", last_word, 16'h0932);
      chk("after_rst resp", resp0(), 8'h06);

`ifdef HOLOBLADE_CMD_CHECKSUM_EN
      // checksum mismatch
      txq.delete();
      s0 = n_start;
      send_byte(8'h57);
      send_byte(8'h09);
      send_byte(8'h32);
      send_byte(8'h00);
      wait_resp(1, "bad_chk");
      chk("bad_chk no spi", n_start - s0, 0);
      chk("bad_chk resp", resp0(), 8'h15);
`endif

      // two-byte data read
      spi_rx_word2 = 16'hBEEF;
      send2(8'h52);
`ifdef HOLOBLADE_CMD_CHECKSUM_EN
      send2(8'hF8);
      send2(8'hAA);
`else
      send2(8'hF8);
`endif
      @(negedge clk);
      chk("d2 start", spi_start2, 1);
      chk("d2 word", spi_tx_word2, 24'hF80000);
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1 spi_done2 = 1'b1;
      @(posedge clk); #1 spi_done2 = 1'b0;
      for (int j = 0; j < 2; j++) begin
         k = 0;
         while (!tx_dv2 && k < 20) begin
            @(posedge clk); #1;
            k++;
         end
         chk($sformatf("d2 dv%0d", j), tx_dv2, 1);
         chk($sformatf("d2 byte%0d", j), tx_byte2,
             (j == 0) ? 8'hBE : 8'hEF);
         @(posedge clk); #1;
         repeat (2) @(posedge clk);
         #1 tx_done2 = 1'b1;
         @(posedge clk); #1 tx_done2 = 1'b0;
      end
      repeat (5) @(posedge clk);
      #1;
      chk("d2 idle", tx_dv2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
